// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry
// and the parity helper used by both directions.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int IDX_W      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  function automatic logic parity_bit(
    input logic [DATA_BITS-1:0] d,
    input logic                 odd
  );
    return odd ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick every CLKS_PER_BIT
// cycles, restartable so a frame starts on a clean boundary.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (tick || clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity,
// stop. Line output is registered from next-state values.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50,
  parameter bit PARITY_ODD   = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  uart_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic           accept;
  logic           tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (CLOCK_50),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          data_d  = tx_data;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = S_PARITY;
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drive tx from the upcoming state so it lands with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[idx_d];
      S_PARITY: tx_d = parity_bit(data_d, PARITY_ODD);
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, with an
// odd-parity and an even-parity instance on shared inputs.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx, busy, done;
  logic       tx_e, busy_e, done_e;

  int checks;
  int errors;

  logic tx_log   [0:127];
  logic busy_log [0:127];
  logic done_log [0:127];
  logic txe_log  [0:127];
  logic busye_log[0:127];

  uart_tx #(
    .CLKS_PER_BIT(4),
    .PARITY_ODD  (1'b1)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  uart_tx #(
    .CLKS_PER_BIT(4),
    .PARITY_ODD  (1'b0)
  ) dut_even (
    .CLOCK_50(clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx_e),
    .busy    (busy_e),
    .done    (done_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] frame(
    input logic [7:0] d,
    input logic       p
  );
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic grab(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[base+i]    = tx;
      busy_log[base+i]  = busy;
      done_log[base+i]  = done;
      txe_log[base+i]   = tx_e;
      busye_log[base+i] = busy_e;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) tx_start = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold i=%0d tx=%b busy=%b done=%b want 1 0 0",
                 i, tx, busy, done);
      end
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    grab(0, 20);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0 ||
          done_log[c] !== 1'b0) begin
        errors++;
        $display("FAIL idle c=%0d tx=%b busy=%b done=%b want 1 0 0",
                 c, tx_log[c], busy_log[c], done_log[c]);
      end
    end
  endtask

  task automatic test_frame_a5();
    logic [10:0] f;
    f = frame(8'hA5, 1'b1);
    send(8'hA5);
    grab(0, 46);
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (tx_log[c] !== f[c/4] || busy_log[c] !== 1'b1 ||
          done_log[c] !== 1'b0) begin
        errors++;
        $display("FAIL a5_bit c=%0d tx=%b busy=%b done=%b want %b 1 0",
                 c, tx_log[c], busy_log[c], done_log[c], f[c/4]);
      end
    end
    checks++;
    if (done_log[44] !== 1'b1 || busy_log[44] !== 1'b0 ||
        tx_log[44] !== 1'b1) begin
      errors++;
      $display("FAIL a5_done tx=%b busy=%b done=%b want 1 0 1",
               tx_log[44], busy_log[44], done_log[44]);
    end
    checks++;
    if (done_log[45] !== 1'b0 || busy_log[45] !== 1'b0) begin
      errors++;
      $display("FAIL a5_after busy=%b done=%b want 0 0",
               busy_log[45], done_log[45]);
    end
  endtask

  task automatic test_parity();
    send(8'h01);
    grab(0, 46);
    for (int c = 36; c < 40; c++) begin
      checks++;
      if (tx_log[c] !== 1'b0) begin
        errors++;
        $display("FAIL par_odd c=%0d tx=%b want 0", c, tx_log[c]);
      end
      checks++;
      if (txe_log[c] !== 1'b1) begin
        errors++;
        $display("FAIL par_even c=%0d tx=%b want 1", c, txe_log[c]);
      end
    end
    checks++;
    if (txe_log[4] !== 1'b1 || txe_log[8] !== 1'b0 ||
        txe_log[40] !== 1'b1 || busye_log[43] !== 1'b1 ||
        busye_log[44] !== 1'b0) begin
      errors++;
      $display("FAIL even_frame d0=%b d1=%b stop=%b busy43=%b busy44=%b want 1 0 1 1 0",
               txe_log[4], txe_log[8], txe_log[40],
               busye_log[43], busye_log[44]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] f;
    f = frame(8'h00, 1'b1);
    send(8'h00);
    grab(0, 10);
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    grab(10, 1);
    tx_start = 1'b0;
    grab(11, 40);
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (tx_log[c] !== f[c/4] || busy_log[c] !== 1'b1) begin
        errors++;
        $display("FAIL ign_bit c=%0d tx=%b busy=%b want %b 1",
                 c, tx_log[c], busy_log[c], f[c/4]);
      end
    end
    checks++;
    if (done_log[44] !== 1'b1) begin
      errors++;
      $display("FAIL ign_done done=%b want 1", done_log[44]);
    end
    for (int c = 45; c < 51; c++) begin
      checks++;
      if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) begin
        errors++;
        $display("FAIL ign_noframe c=%0d tx=%b busy=%b want 1 0",
                 c, tx_log[c], busy_log[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f;
    f        = frame(8'h3C, 1'b1);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    grab(0, 45);
    tx_start = 1'b0;
    grab(45, 46);
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (tx_log[c] !== f[c/4] || tx_log[45+c] !== f[c/4] ||
          busy_log[45+c] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit c=%0d tx1=%b tx2=%b busy2=%b want %b %b 1",
                 c, tx_log[c], tx_log[45+c], busy_log[45+c],
                 f[c/4], f[c/4]);
      end
    end
    for (int c = 40; c < 45; c++) begin
      checks++;
      if (tx_log[c] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap c=%0d tx=%b want 1", c, tx_log[c]);
      end
    end
    checks++;
    if (done_log[44] !== 1'b1 || tx_log[45] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart done44=%b tx45=%b want 1 0",
               done_log[44], tx_log[45]);
    end
    checks++;
    if (done_log[89] !== 1'b1 || busy_log[90] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done2 done89=%b busy90=%b want 1 0",
               done_log[89], busy_log[90]);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    send(8'hF0);
    grab(0, 18);
    checks++;
    if (tx_log[16] !== 1'b0 || tx_log[17] !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3 tx16=%b tx17=%b want 0 0",
               tx_log[16], tx_log[17]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    grab(18, 40);
    checks++;
    if (tx_log[18] !== 1'b1 || busy_log[18] !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort tx=%b busy=%b want 1 0",
               tx_log[18], busy_log[18]);
    end
    for (int c = 19; c < 58; c++) begin
      checks++;
      if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0 ||
          done_log[c] !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet c=%0d tx=%b busy=%b done=%b want 1 0 0",
                 c, tx_log[c], busy_log[c], done_log[c]);
      end
    end
    f = frame(8'h55, 1'b1);
    send(8'h55);
    grab(0, 46);
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (tx_log[c] !== f[c/4] || busy_log[c] !== 1'b1) begin
        errors++;
        $display("FAIL mid_55 c=%0d tx=%b busy=%b want %b 1",
                 c, tx_log[c], busy_log[c], f[c/4]);
      end
    end
    checks++;
    if (done_log[44] !== 1'b1 || done_log[45] !== 1'b0) begin
      errors++;
      $display("FAIL mid_55_done d44=%b d45=%b want 1 0",
               done_log[44], done_log[45]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_frame_a5();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
